rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: DEPTH, 4, long-latency queue entries (power of two, 2..16).
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 alu_we  input  1  single-cycle result valid; no backpressure.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 lp_valid  input  1  long-latency result (mul/div/load) valid.
REQ-008 lp_ready  output  1  queue can accept an lp result.
REQ-009 lp_rd  input  5  long-latency destination register.
REQ-010 lp_data  input  32  long-latency result.
REQ-011 RF_w  output  1  register-file write enable, registered.
REQ-012 rd  output  5  register-file write address, registered.
REQ-013 rd_data  output  32  register-file write data, registered.
REQ-014 q_count  output  clog2(DEPTH)+1  entries currently queued.
REQ-015 q_rs, q_rt  input  5 each  scoreboard query addresses (present only with RF_WB_SCOREBOARD_EN).
REQ-016 q_rs_busy, q_rt_busy  output  1 each  queried register has a queued write (present only with RF_WB_SCOREBOARD_EN).

Function
REQ-017 lp_ready SHALL equal (q_count != DEPTH); it SHALL NOT depend on same-cycle pops.
REQ-018 lp accept = lp_valid && lp_ready; accepted entry with lp_rd != 0 SHALL be pushed at tail; lp_rd == 0 SHALL be accepted and discarded.
REQ-019 Arbitration per cycle, fixed priority: ALU write (alu_we && alu_rd != 0) first, else queue head, else idle.
REQ-020 Chosen write SHALL appear on RF_w/rd/rd_data exactly one cycle after selection; when idle, RF_w SHALL be 0 next cycle and rd/rd_data hold.
REQ-021 alu_we with alu_rd == 0 SHALL be treated as idle (queue may drain that cycle).
REQ-022 Ordering: an ALU write to register X SHALL invalidate every queued valid entry with rd == X in the same cycle, including one accepted that same cycle.
REQ-023 Invalidated head entries SHALL be popped without producing a write, at most one pop per cycle, and count toward q_count until popped.
REQ-024 Queue SHALL be FIFO; head/tail pointers wrap modulo DEPTH; simultaneous push and pop SHALL leave q_count unchanged.
REQ-025 Queue head SHALL drain only in cycles with no qualifying ALU write; sustained ALU writes MAY starve the queue indefinitely.
REQ-026 At most one register-file write per cycle; RF_w SHALL never be 1 with rd == 0.

Reset
REQ-027 On rst: RF_w=0, rd=0, rd_data=0, q_count=0, all entry valid bits 0, pointers 0, lp_ready=1 once rst deasserts.
REQ-028 rst mid-operation SHALL discard all queued results with no write issued; an in-flight lp_valid during rst SHALL NOT be accepted.

Configuration
REQ-029 Macro RF_WB_SCOREBOARD_EN defined: q_rs_busy/q_rt_busy SHALL be combinational, 1 iff a valid queued entry (not invalidated) targets the queried nonzero register; also 1 if the registered output is writing that register this cycle.
REQ-030 Macro RF_WB_SCOREBOARD_EN undefined: q_rs, q_rt, q_rs_busy, q_rt_busy ports and scoreboard logic SHALL be absent.

Verification
REQ-031 ALU only: alu_we=1, alu_rd=5, alu_data=0x12345678 at cycle N -> RF_w=1, rd=5, rd_data=0x12345678 at cycle N+1; q_count=0.
REQ-032 Fill: 4 lp pushes (rd=8..11) with alu_we=1 to r1 each cycle -> q_count=4, lp_ready=0; drop alu_we -> writes r8,r9,r10,r11 in order on 4 consecutive cycles, lp_ready=1 after first pop.
REQ-033 Ordering: queue lp rd=7 data=0xAAAA, same cycle ALU rd=7 data=0xBBBB -> one write r7=0xBBBB; queued entry popped silently; r7 never becomes 0xAAAA.
REQ-034 Zero register: lp_rd=0 accepted, alu_rd=0 alu_we=1 -> RF_w stays 0, q_count stays 0.
REQ-035 Reset mid-drain: 3 entries queued, assert rst for 1 cycle -> RF_w=0, q_count=0, no further writes.
REQ-036 Scoreboard (RF_WB_SCOREBOARD_EN): queue rd=12, q_rs=12 -> q_rs_busy=1 until the cycle after r12 write issues, then 0; q_rt=0 -> q_rt_busy=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: single-cycle ALU results take priority over a FIFO of
// long-latency results. Optional busy-register scoreboard under RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_we,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       lp_valid,
    output logic                       lp_ready,
    input  logic [4:0]                 lp_rd,
    input  logic [31:0]                lp_data,
    output logic                       RF_w,
    output logic [4:0]                 rd,
    output logic [31:0]                rd_data,
`ifdef RF_WB_SCOREBOARD_EN
    input  logic [4:0]                 q_rs,
    input  logic [4:0]                 q_rt,
    output logic                       q_rs_busy,
    output logic                       q_rt_busy,
`endif
    output logic [$clog2(DEPTH):0]     q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]        ent_vld_q, ent_vld_d;
    logic [DEPTH-1:0][4:0]   ent_rd_q, ent_rd_d;
    logic [DEPTH-1:0][31:0]  ent_data_q, ent_data_d;
    logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    rf_w_q, rf_w_d;
    logic [4:0]              rd_q, rd_d;
    logic [31:0]             rd_data_q, rd_data_d;

    logic alu_sel, pop, push;

    assign lp_ready = (count_q != CW'(DEPTH));
    assign q_count  = count_q;
    assign RF_w     = rf_w_q;
    assign rd       = rd_q;
    assign rd_data  = rd_data_q;

    always_comb begin
        ent_vld_d  = ent_vld_q;
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        rf_w_d     = 1'b0;
        rd_d       = rd_q;
        rd_data_d  = rd_data_q;

        alu_sel = alu_we && (alu_rd != 5'd0);
        pop     = !alu_sel && (count_q != '0);
        push    = lp_valid && lp_ready && (lp_rd != 5'd0);

        // A younger ALU write supersedes every queued result for the same register.
        if (alu_sel) begin
            for (int i = 0; i < DEPTH; i++)
                if (ent_rd_q[i] == alu_rd) ent_vld_d[i] = 1'b0;
            rf_w_d    = 1'b1;
            rd_d      = alu_rd;
            rd_data_d = alu_data;
        end else if (pop) begin
            if (ent_vld_q[head_q]) begin
                rf_w_d    = 1'b1;
                rd_d      = ent_rd_q[head_q];
                rd_data_d = ent_data_q[head_q];
            end
            ent_vld_d[head_q] = 1'b0;
            head_d            = head_q + PW'(1);
        end

        if (push) begin
            ent_vld_d[tail_q]  = !(alu_sel && (alu_rd == lp_rd));
            ent_rd_d[tail_q]   = lp_rd;
            ent_data_d[tail_q] = lp_data;
            tail_d             = tail_q + PW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld_q  <= '0;
            ent_rd_q   <= '0;
            ent_data_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_w_q     <= 1'b0;
            rd_q       <= '0;
            rd_data_q  <= '0;
        end else begin
            ent_vld_q  <= ent_vld_d;
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_w_q     <= rf_w_d;
            rd_q       <= rd_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    // Busy covers queued valid entries plus the write currently on the RF port.
    always_comb begin
        q_rs_busy = 1'b0;
        q_rt_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && ent_rd_q[i] == q_rs) q_rs_busy = 1'b1;
            if (ent_vld_q[i] && ent_rd_q[i] == q_rt) q_rt_busy = 1'b1;
        end
        if (rf_w_q && rd_q == q_rs) q_rs_busy = 1'b1;
        if (rf_w_q && rd_q == q_rt) q_rt_busy = 1'b1;
        if (q_rs == 5'd0) q_rs_busy = 1'b0;
        if (q_rt == 5'd0) q_rt_busy = 1'b0;
    end
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: ALU path, queue fill/drain, ordering, r0, reset, scoreboard.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lp_valid;
    logic        lp_ready;
    logic [4:0]  lp_rd;
    logic [31:0] lp_data;
    logic        RF_w;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [2:0]  q_count;
`ifdef RF_WB_SCOREBOARD_EN
    logic [4:0]  q_rs, q_rt;
    logic        q_rs_busy, q_rt_busy;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
        .lp_valid(lp_valid), .lp_ready(lp_ready), .lp_rd(lp_rd), .lp_data(lp_data),
        .RF_w(RF_w), .rd(rd), .rd_data(rd_data),
`ifdef RF_WB_SCOREBOARD_EN
        .q_rs(q_rs), .q_rt(q_rt), .q_rs_busy(q_rs_busy), .q_rt_busy(q_rt_busy),
`endif
        .q_count(q_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic awe, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        alu_we = awe; alu_rd = ard; alu_data = ad;
        lp_valid = lv; lp_rd = lr; lp_data = ld;
    endtask

    task automatic chk_out(input string tag, input logic w, input logic [4:0] r,
                           input logic [31:0] d, input logic [2:0] c);
        chk({tag, ".RF_w"}, 32'(RF_w), 32'(w));
        if (w) begin
            chk({tag, ".rd"}, 32'(rd), 32'(r));
            chk({tag, ".rd_data"}, rd_data, d);
        end
        chk({tag, ".q_count"}, 32'(q_count), 32'(c));
    endtask

    initial begin
        rst = 1'b1;
`ifdef RF_WB_SCOREBOARD_EN
        q_rs = 5'd0; q_rt = 5'd0;
`endif
        drive(0, 0, 0, 0, 0, 0);
        step(); step();
        chk("rst.RF_w", 32'(RF_w), 32'd0);
        chk("rst.rd", 32'(rd), 32'd0);
        chk("rst.rd_data", rd_data, 32'd0);
        chk("rst.q_count", 32'(q_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.lp_ready", 32'(lp_ready), 32'd1);

        // ALU only
        drive(1, 5, 32'h12345678, 0, 0, 0);
        step();
        chk_out("alu", 1, 5, 32'h12345678, 0);

        // Fill queue under continuous ALU traffic to r1
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'(100 + k), 1, 5'(8 + k), 32'h800 + 32'(k));
            step();
            chk_out($sformatf("fill%0d", k), 1, 1, 32'(100 + k), 3'(k + 1));
        end
        chk("full.lp_ready", 32'(lp_ready), 32'd0);
        drive(1, 1, 32'h55, 1, 20, 32'h2020);
        step();
        chk_out("full_reject", 1, 1, 32'h55, 4);

        // Drain in order; second pop overlaps a push
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_out("drain8", 1, 8, 32'h800, 3);
        chk("drain.lp_ready", 32'(lp_ready), 32'd1);
        drive(0, 0, 0, 1, 15, 32'hF);
        step();
        chk_out("drain9_push", 1, 9, 32'h801, 3);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_out("drain10", 1, 10, 32'h802, 2);
        step();
        chk_out("drain11", 1, 11, 32'h803, 1);
        step();
        chk_out("drain15", 1, 15, 32'hF, 0);
        step();
        chk_out("idle", 0, 0, 0, 0);
        chk("idle.rd_hold", 32'(rd), 32'd15);
        chk("idle.data_hold", rd_data, 32'hF);

        // Same-cycle ALU write invalidates the entry being accepted
        drive(1, 7, 32'hBBBB, 1, 7, 32'hAAAA);
        step();
        chk_out("ord_same", 1, 7, 32'hBBBB, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_out("ord_silent", 0, 0, 0, 0);
        chk("ord.data_hold", rd_data, 32'hBBBB);

        // ALU write invalidates an already-queued entry
        drive(1, 1, 32'h11, 1, 3, 32'h33);
        step();
        chk_out("inv_push", 1, 1, 32'h11, 1);
        drive(1, 3, 32'h44, 0, 0, 0);
        step();
        chk_out("inv_alu", 1, 3, 32'h44, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_out("inv_silent", 0, 0, 0, 0);

        // Register zero on both sides
        drive(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        step();
        chk_out("r0", 0, 0, 0, 0);
        drive(1, 1, 32'h12, 1, 6, 32'h66);
        step();
        chk_out("r0_push", 1, 1, 32'h12, 1);
        drive(1, 0, 32'hDEAD, 0, 0, 0);
        step();
        chk_out("r0_drain", 1, 6, 32'h66, 0);

        // Reset mid-operation with lp_valid held high
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 32'h70 + 32'(k), 1, 5'(20 + k), 32'h900 + 32'(k));
            step();
        end
        chk_out("pre_rst", 1, 1, 32'h72, 3);
        drive(0, 0, 0, 1, 25, 32'h999);
        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        step();
        chk_out("rst_hold", 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out($sformatf("post_rst%0d", k), 0, 0, 0, 0);
        end

`ifdef RF_WB_SCOREBOARD_EN
        q_rs = 5'd12; q_rt = 5'd0;
        drive(1, 1, 32'h1, 1, 12, 32'hC);
        step();
        chk("sb.rs_queued", 32'(q_rs_busy), 32'd1);
        chk("sb.rt_zero", 32'(q_rt_busy), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_out("sb_write", 1, 12, 32'hC, 0);
        chk("sb.rs_writing", 32'(q_rs_busy), 32'd1);
        step();
        chk("sb.rs_clear", 32'(q_rs_busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
